ctrl_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit Mini SRC datapath and its 512x32 memory.
- Sequences instruction fetch, decode and execute by driving the datapath control signals that the System testbenches currently hand-drive per T-state.
- Supports ALU register, ALU immediate, ld/ldi/st, nop and halt.
- Stretches memory T-states on the memory_done handshake, with a timeout fault.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 33 +++
 rtl/ctrl_sequencer.sv | 161 ++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the Mini SRC hardwired control unit.
//   - 5-bit instruction opcodes (IR[31:27]) and the ALU operation codes driven on `opcode`
//   - 4-bit sequencer state encoding
//   - opcode class used to pick the T3..T7 strobes
package ctrl_pkg;

    // Instruction opcodes
    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpShr  = 5'b00111;
    localparam logic [4:0] OpShl  = 5'b01000;
    localparam logic [4:0] OpRor  = 5'b01001;
    localparam logic [4:0] OpRol  = 5'b01010;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    // ALU operation select; register-form ALU ops use their own opcode value
    localparam logic [4:0] AluNone = 5'b00000;
    localparam logic [4:0] AluAdd  = OpAdd;
    localparam logic [4:0] AluAnd  = OpAnd;
    localparam logic [4:0] AluOr   = OpOr;

    typedef enum logic [3:0] {
        StReset = 4'd0,
        StT0    = 4'd1,
        StT1    = 4'd2,
        StT1W   = 4'd3,
        StT2    = 4'd4,
        StT3    = 4'd5,
        StT4    = 4'd6,
        StT5    = 4'd7,
        StT6    = 4'd8,
        StT6S   = 4'd9,
        StT7    = 4'd10,
        StHalt  = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ClsAluR,
        ClsAluI,
        ClsLd,
        ClsLdi,
        ClsSt,
        ClsNop,
        ClsHalt,
        ClsIllegal
    } cls_e;

    // Classes that continue past T5 into a memory data phase
    function automatic logic is_mem_class(cls_e c);
        return (c == ClsLd) || (c == ClsSt);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode decoder.
//   op_field  in  5  IR[31:27]
//   cls       out    opcode class (ClsIllegal for unassigned codes)
//   alu_op    out 5  ALU operation to use in T4 (immediates mapped, memory ops use add)
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] op_field,
    output cls_e       cls,
    output logic [4:0] alu_op
);

    always_comb begin
        cls    = ClsIllegal;
        alu_op = AluNone;
        case (op_field)
            OpLd:  begin cls = ClsLd;  alu_op = AluAdd; end
            OpLdi: begin cls = ClsLdi; alu_op = AluAdd; end
            OpSt:  begin cls = ClsSt;  alu_op = AluAdd; end
            OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl, OpRor, OpRol: begin
                cls    = ClsAluR;
                alu_op = op_field;
            end
            OpAddi: begin cls = ClsAluI; alu_op = AluAdd; end
            OpAndi: begin cls = ClsAluI; alu_op = AluAnd; end
            OpOri:  begin cls = ClsAluI; alu_op = AluOr;  end
            OpNop:  cls = ClsNop;
            OpHalt: cls = ClsHalt;
            default: cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired Moore control unit for the Mini SRC datapath.
//   Clock, clear         clock and asynchronous active-high reset
//   IR                   instruction register (opcode in the top 5 bits)
//   memory_done          memory handshake, stretches T1W/T6/T6S
//   PCout..BAout         datapath strobes
//   Gra/Grb/Grc/Rin/Rout register select and enables
//   opcode               ALU operation, nonzero only in T4
//   Mem_*                memory controls
//   run                  high while sequencing (not RESET/HALT)
//   mem_fault            sticky memory-timeout flag
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  memory_done,
    output logic PCout, IncPC, MARin, Zin, Zlo_out, PCin,
    output logic MDRin, MDRout, IRin, Yin, Cout, BAout,
    output logic Gra, Grb, Grc, Rin, Rout,
    output logic [4:0] opcode,
    output logic Mem_Read, Mem_Write, Mem_enable512x32,
    output logic run,
    output logic mem_fault
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    cls_e            cls_q, cls_d, dec_cls;
    logic [4:0]      alu_op_q, alu_op_d, dec_alu_op;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_fault_q, mem_fault_d;
    logic            waiting;

    logic unused_ir;
    assign unused_ir = ^IR[DATA_WIDTH-6:0];

    ctrl_decode u_decode (
        .op_field (IR[DATA_WIDTH-1 -: 5]),
        .cls      (dec_cls),
        .alu_op   (dec_alu_op)
    );

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q     <= StReset;
            cls_q       <= ClsNop;
            alu_op_q    <= AluNone;
            wait_cnt_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            alu_op_q    <= alu_op_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_fault_q <= mem_fault_d;
        end
    end

    // Next state. wait_cnt defaults to 0 so any state change (entry, memory_done) clears it.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        alu_op_d    = alu_op_q;
        wait_cnt_d  = '0;
        mem_fault_d = mem_fault_q;
        waiting     = 1'b0;
        unique case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = memory_done ? StT2 : StT1W;
            StT1W: begin
                if (memory_done) state_d = StT2;
                else             waiting = 1'b1;
            end
            StT2: begin
                state_d  = StT3;
                cls_d    = dec_cls;
                alu_op_d = dec_alu_op;
            end
            StT3: begin
                case (cls_q)
                    ClsNop:              state_d = StT0;
                    ClsHalt, ClsIllegal: state_d = StHalt;
                    default:             state_d = StT4;
                endcase
            end
            StT4: state_d = StT5;
            StT5: state_d = is_mem_class(cls_q) ? StT6 : StT0;
            StT6: begin
                // st uses T6 only to put the source register on MDR; no handshake here
                if (cls_q == ClsSt)   state_d = StT6S;
                else if (memory_done) state_d = StT7;
                else                  waiting = 1'b1;
            end
            StT6S: begin
                if (memory_done) state_d = StT0;
                else             waiting = 1'b1;
            end
            StT7:    state_d = StT0;
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase

        if (waiting && (MEM_TIMEOUT != 0)) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
            if (wait_cnt_d == TimeoutVal) begin
                wait_cnt_d  = '0;
                mem_fault_d = 1'b1;
                state_d     = StHalt;
            end
        end
    end

    // Moore output decode from registered state and latched class only.
    always_comb begin
        {PCout, IncPC, MARin, Zin, Zlo_out, PCin} = '0;
        {MDRin, MDRout, IRin, Yin, Cout, BAout}   = '0;
        {Gra, Grb, Grc, Rin, Rout}                = '0;
        {Mem_Read, Mem_Write, Mem_enable512x32}   = '0;
        opcode    = AluNone;
        run       = (state_q != StReset) && (state_q != StHalt);
        mem_fault = mem_fault_q;
        unique case (state_q)
            StT0: {PCout, IncPC, MARin, Zin} = '1;
            StT1: {Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32} = '1;
            StT1W: {MDRin, Mem_Read, Mem_enable512x32} = '1;
            StT2: {MDRout, IRin} = '1;
            StT3: begin
                case (cls_q)
                    ClsAluR, ClsAluI:    {Grb, Rout, Yin} = '1;
                    ClsLd, ClsLdi, ClsSt: {Grb, BAout, Yin} = '1;
                    default: ;
                endcase
            end
            StT4: begin
                opcode = alu_op_q;
                if (cls_q == ClsAluR) {Grc, Rout, Zin} = '1;
                else                  {Cout, Zin} = '1;
            end
            StT5: begin
                if (is_mem_class(cls_q)) {Zlo_out, MARin} = '1;
                else                     {Zlo_out, Gra, Rin} = '1;
            end
            StT6: begin
                // Mem_Read low steers the MDR input mux to the bus for st
                if (cls_q == ClsSt) {Gra, Rout, MDRin} = '1;
                else                {MDRin, Mem_Read, Mem_enable512x32} = '1;
            end
            StT6S: {Mem_Write, Mem_enable512x32} = '1;
            StT7: {MDRout, Gra, Rin} = '1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = 32'h0;
    logic        memory_done = 1'b0;
    logic PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin, Yin, Cout, BAout;
    logic Gra, Grb, Grc, Rin, Rout, Mem_Read, Mem_Write, Mem_enable512x32, run, mem_fault;
    logic [4:0] opcode;

    ctrl_sequencer #(.DATA_WIDTH(32), .MEM_TIMEOUT(15)) dut (
        .Clock(Clock), .clear(clear), .IR(IR), .memory_done(memory_done),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Zin(Zin), .Zlo_out(Zlo_out),
        .PCin(PCin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Cout(Cout),
        .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .opcode(opcode), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_enable512x32(Mem_enable512x32), .run(run), .mem_fault(mem_fault)
    );

    always #5 Clock = ~Clock;

    // Observed outputs packed as {strobes, mem ctl, run, fault, opcode}
    logic [26:0] obs;
    assign obs = {PCout, IncPC, MARin, Zin, Zlo_out, PCin, MDRin, MDRout, IRin, Yin, Cout,
                  BAout, Gra, Grb, Grc, Rin, Rout, Mem_Read, Mem_Write, Mem_enable512x32,
                  run, mem_fault, opcode};

    localparam logic [26:0] SPcOut  = 27'd1 << 26, SIncPc  = 27'd1 << 25, SMarIn = 27'd1 << 24;
    localparam logic [26:0] SZIn    = 27'd1 << 23, SZloOut = 27'd1 << 22, SPcIn  = 27'd1 << 21;
    localparam logic [26:0] SMdrIn  = 27'd1 << 20, SMdrOut = 27'd1 << 19, SIrIn  = 27'd1 << 18;
    localparam logic [26:0] SYIn    = 27'd1 << 17, SCout   = 27'd1 << 16, SBaOut = 27'd1 << 15;
    localparam logic [26:0] SGra    = 27'd1 << 14, SGrb    = 27'd1 << 13, SGrc   = 27'd1 << 12;
    localparam logic [26:0] SRin    = 27'd1 << 11, SRout   = 27'd1 << 10, SMemRd = 27'd1 << 9;
    localparam logic [26:0] SMemWr  = 27'd1 << 8,  SMemEn  = 27'd1 << 7,  SRun   = 27'd1 << 6;
    localparam logic [26:0] SFault  = 27'd1 << 5;

    localparam logic [26:0] ExT0  = SPcOut | SIncPc | SMarIn | SZIn | SRun;
    localparam logic [26:0] ExT1  = SZloOut | SPcIn | SMdrIn | SMemRd | SMemEn | SRun;
    localparam logic [26:0] ExT1W = SMdrIn | SMemRd | SMemEn | SRun;
    localparam logic [26:0] ExT2  = SMdrOut | SIrIn | SRun;
    localparam logic [26:0] ExT3R = SGrb | SRout | SYIn | SRun;
    localparam logic [26:0] ExT3M = SGrb | SBaOut | SYIn | SRun;
    localparam logic [26:0] ExT4I = SCout | SZIn | SRun;
    localparam logic [26:0] ExT4R = SGrc | SRout | SZIn | SRun;
    localparam logic [26:0] ExT5W = SZloOut | SGra | SRin | SRun;
    localparam logic [26:0] ExT5M = SZloOut | SMarIn | SRun;
    localparam logic [26:0] ExT6L = SMdrIn | SMemRd | SMemEn | SRun;
    localparam logic [26:0] ExT6S = SGra | SRout | SMdrIn | SRun;
    localparam logic [26:0] ExT6W = SMemWr | SMemEn | SRun;
    localparam logic [26:0] ExT7  = SMdrOut | SGra | SRin | SRun;

    localparam logic [31:0] IrAddi = 32'h619FFFFB, IrSub  = 32'h21890000;
    localparam logic [31:0] IrLd   = 32'h008001F4, IrSt   = 32'h108001F5;
    localparam logic [31:0] IrNop  = 32'hD0000000, IrLdi  = 32'h08000000;
    localparam logic [31:0] IrOri  = 32'h70000000, IrRol  = 32'h50000000;
    localparam logic [31:0] IrHalt = 32'hD8000000, IrAndi = 32'h68000000;
    localparam logic [31:0] IrBad  = 32'h58000000;

    typedef struct {
        logic [31:0] ir;
        logic        md;
        logic [26:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [26:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, obs, exp, $time);
        end
    endtask

    // Drive inputs for the current state, check its outputs, advance one clock.
    task automatic step(input logic [31:0] ir, input logic md, input logic [26:0] exp,
                        input string name);
        IR = ir;
        memory_done = md;
        chk(name, exp);
        @(posedge Clock);
        #1;
    endtask

    task automatic add(input logic [31:0] ir, input logic md, input logic [26:0] exp,
                       input string name);
        tbl.push_back('{ir, md, exp, name});
    endtask

    task automatic add_fetch(input logic [31:0] ir, input string name);
        add(ir, 1'b0, ExT0, {name, ".T0"});
        add(ir, 1'b1, ExT1, {name, ".T1"});
        add(ir, 1'b0, ExT2, {name, ".T2"});
    endtask

    task automatic pulse_clear();
        @(negedge Clock);
        clear = 1'b1;
        #1;
        chk("clear_async", 27'd0);
        @(negedge Clock);
        clear = 1'b0;
        chk("reset_state", 27'd0);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        // Table: instruction stream applied one state per clock
        add(32'h0, 1'b0, 27'd0, "reset");
        add_fetch(IrAddi, "addi");
        add(IrAddi, 1'b0, ExT3R, "addi.T3");
        add(IrAddi, 1'b0, ExT4I | 27'd3, "addi.T4");
        add(IrAddi, 1'b0, ExT5W, "addi.T5");
        // Fetch stretched by 3 wait cycles; memory_done in T0 is ignored
        add(IrSub, 1'b1, ExT0, "sub.T0");
        add(IrSub, 1'b0, ExT1, "sub.T1");
        add(IrSub, 1'b0, ExT1W, "sub.T1W1");
        add(IrSub, 1'b0, ExT1W, "sub.T1W2");
        add(IrSub, 1'b1, ExT1W, "sub.T1W3");
        add(IrSub, 1'b0, ExT2, "sub.T2");
        add(IrSub, 1'b0, ExT3R, "sub.T3");
        add(IrSub, 1'b0, ExT4R | 27'd4, "sub.T4");
        add(IrSub, 1'b0, ExT5W, "sub.T5");
        add_fetch(IrLd, "ld");
        add(IrLd, 1'b0, ExT3M, "ld.T3");
        add(IrLd, 1'b0, ExT4I | 27'd3, "ld.T4");
        add(IrLd, 1'b0, ExT5M, "ld.T5");
        add(IrLd, 1'b1, ExT6L, "ld.T6");
        add(IrLd, 1'b0, ExT7, "ld.T7");
        add_fetch(IrSt, "st");
        add(IrSt, 1'b0, ExT3M, "st.T3");
        add(IrSt, 1'b0, ExT4I | 27'd3, "st.T4");
        add(IrSt, 1'b0, ExT5M, "st.T5");
        add(IrSt, 1'b0, ExT6S, "st.T6");
        add(IrSt, 1'b1, ExT6W, "st.T6S");
        add_fetch(IrLd, "ldw");
        add(IrLd, 1'b0, ExT3M, "ldw.T3");
        add(IrLd, 1'b0, ExT4I | 27'd3, "ldw.T4");
        add(IrLd, 1'b0, ExT5M, "ldw.T5");
        add(IrLd, 1'b0, ExT6L, "ldw.T6a");
        add(IrLd, 1'b0, ExT6L, "ldw.T6b");
        add(IrLd, 1'b1, ExT6L, "ldw.T6c");
        add(IrLd, 1'b0, ExT7, "ldw.T7");
        add_fetch(IrNop, "nop");
        add(IrNop, 1'b0, SRun, "nop.T3");
        add_fetch(IrLdi, "ldi");
        add(IrLdi, 1'b0, ExT3M, "ldi.T3");
        add(IrLdi, 1'b0, ExT4I | 27'd3, "ldi.T4");
        add(IrLdi, 1'b0, ExT5W, "ldi.T5");
        add_fetch(IrOri, "ori");
        add(IrOri, 1'b0, ExT3R, "ori.T3");
        add(IrOri, 1'b0, ExT4I | 27'd6, "ori.T4");
        add(IrOri, 1'b0, ExT5W, "ori.T5");
        add_fetch(IrRol, "rol");
        add(IrRol, 1'b0, ExT3R, "rol.T3");
        add(IrRol, 1'b0, ExT4R | 27'd10, "rol.T4");
        add(IrRol, 1'b0, ExT5W, "rol.T5");
        add_fetch(IrHalt, "halt");
        add(IrHalt, 1'b0, SRun, "halt.T3");

        @(negedge Clock);
        clear = 1'b0;
        foreach (tbl[i]) step(tbl[i].ir, tbl[i].md, tbl[i].exp, tbl[i].name);

        // HALT is terminal: stays quiet even with memory_done and new IR
        for (int i = 0; i < 20; i++) step(IrAdd(i), 1'b1, 27'd0, "halt_hold");

        // clear during T4 of andi drops everything immediately, restarts at T0
        pulse_clear();
        step(IrAndi, 1'b0, ExT0, "andi.T0");
        step(IrAndi, 1'b1, ExT1, "andi.T1");
        step(IrAndi, 1'b0, ExT2, "andi.T2");
        step(IrAndi, 1'b0, ExT3R, "andi.T3");
        chk("andi.T4", ExT4I | 27'd5);
        #2;
        clear = 1'b1;
        #1;
        chk("andi.clear_same_delta", 27'd0);
        @(posedge Clock);
        #1;
        chk("andi.clear_held", 27'd0);
        @(negedge Clock);
        clear = 1'b0;
        chk("andi.released", 27'd0);
        @(posedge Clock);
        #1;

        // Fetch timeout: 15 cycles in T1W then HALT with sticky fault
        step(IrAddi, 1'b0, ExT0, "tmo.T0");
        step(IrAddi, 1'b0, ExT1, "tmo.T1");
        for (int i = 0; i < 15; i++) step(IrAddi, 1'b0, ExT1W, "tmo.T1W");
        for (int i = 0; i < 3; i++) step(IrAddi, 1'b1, SFault, "tmo.halt_fault");
        pulse_clear();

        // ld data-phase timeout: 15 cycles in T6
        step(IrLd, 1'b0, ExT0, "tmo_ld.T0");
        step(IrLd, 1'b1, ExT1, "tmo_ld.T1");
        step(IrLd, 1'b0, ExT2, "tmo_ld.T2");
        step(IrLd, 1'b0, ExT3M, "tmo_ld.T3");
        step(IrLd, 1'b0, ExT4I | 27'd3, "tmo_ld.T4");
        step(IrLd, 1'b0, ExT5M, "tmo_ld.T5");
        for (int i = 0; i < 15; i++) step(IrLd, 1'b0, ExT6L, "tmo_ld.T6");
        step(IrLd, 1'b0, SFault, "tmo_ld.halt_fault");
        pulse_clear();

        // Illegal opcode halts after T3
        step(IrBad, 1'b0, ExT0, "bad.T0");
        step(IrBad, 1'b1, ExT1, "bad.T1");
        step(IrBad, 1'b0, ExT2, "bad.T2");
        step(IrBad, 1'b0, SRun, "bad.T3");
        step(IrBad, 1'b0, 27'd0, "bad.halt");
        step(IrBad, 1'b0, 27'd0, "bad.halt_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Varied opcode values presented while halted
    function automatic logic [31:0] IrAdd(input int i);
        return {5'(i + 3), 27'h0};
    endfunction

endmodule
